// File: rtl/duty_ctrl_pkg.sv
// ============================================================================
//  Module   : duty_ctrl_pkg
//  Purpose  : Shared widths, FSM state encoding and counter sizing helper for
//             the duty-cycle command stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package duty_ctrl_pkg;

  localparam int DUTY_W       = 7;
  localparam int DUTY_MAX_PCT = 100;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_RELEASE = 2'd1,
    HOLD         = 2'd2,
    REPEAT       = 2'd3
  } duty_state_t;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
//  Module   : button_debouncer
//  Purpose  : Two-flop synchroniser, stability-counter debounce and a
//             one-cycle press pulse on the rising edge of the debounced level.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer
  import duty_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Synchronise the raw button, then accept a level change only after it has
  // disagreed with the debounced level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        press <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/duty_cycle_ctrl.sv
// ============================================================================
//  Module   : duty_cycle_ctrl
//  Purpose  : Push-button up/down command stage producing a saturating duty
//             percentage for pwm_generator. Optional auto-repeat while a
//             single button is held, enabled by DUTY_CTRL_AUTOREPEAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module duty_cycle_ctrl
  import duty_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int STEP            = 10,
  parameter int INIT_DUTY       = 50,
  parameter int MAX_DUTY        = DUTY_MAX_PCT,
  parameter int REPEAT_DELAY    = 100,
  parameter int REPEAT_PERIOD   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_down,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              duty_valid,
  output logic              at_max,
  output logic              at_min
);

  localparam logic [7:0]        STEP8 = 8'(STEP);
  localparam logic [7:0]        MAX8  = 8'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] MAX7  = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] INIT7 = DUTY_W'(INIT_DUTY);

  logic up_level, up_press, dn_level, dn_press;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_up),
    .level (up_level),
    .press (up_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_down),
    .level (dn_level),
    .press (dn_press)
  );

  duty_state_t       state;
  logic [7:0]        sum8;
  logic [DUTY_W-1:0] nxt_up;
  logic [DUTY_W-1:0] nxt_dn;
  logic              step_up_sel;
  logic [DUTY_W-1:0] step_val;

`ifdef DUTY_CTRL_AUTOREPEAT_EN
  localparam int            RW         = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                                   REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          dir_up;
  logic [RW-1:0] rpt_cnt;
  logic          hold_broken;

  // A hold ends when the held button releases or the other one asserts.
  assign hold_broken = dir_up ? (!up_level || dn_level) : (!dn_level || up_level);
  assign step_up_sel = (state == IDLE) ? up_press : dir_up;
`else
  logic unused_rpt;

  assign unused_rpt  = (REPEAT_DELAY != REPEAT_PERIOD);
  assign step_up_sel = up_press;
`endif

  // Saturating candidates for both directions, computed in 8 bits so the
  // up-sum cannot overflow before it is clamped.
  always_comb begin
    sum8     = {1'b0, duty_cycle} + STEP8;
    nxt_up   = (sum8 > MAX8) ? MAX7 : sum8[DUTY_W-1:0];
    nxt_dn   = ({1'b0, duty_cycle} < STEP8) ? '0 : (duty_cycle - STEP8[DUTY_W-1:0]);
    step_val = step_up_sel ? nxt_up : nxt_dn;
  end

  // Command FSM; owns duty_cycle and its registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      duty_cycle <= INIT7;
      duty_valid <= 1'b0;
      at_max     <= (INIT7 == MAX7);
      at_min     <= (INIT7 == '0);
`ifdef DUTY_CTRL_AUTOREPEAT_EN
      dir_up     <= 1'b0;
      rpt_cnt    <= '0;
`endif
    end else begin
      duty_valid <= 1'b0;
      case (state)
        IDLE: begin
          if ((up_press && dn_press) || (up_level && dn_level)) begin
            state <= WAIT_RELEASE;
          end else if ((up_press && !dn_level) || (dn_press && !up_level)) begin
            duty_cycle <= step_val;
            duty_valid <= (step_val != duty_cycle);
            at_max     <= (step_val == MAX7);
            at_min     <= (step_val == '0);
`ifdef DUTY_CTRL_AUTOREPEAT_EN
            dir_up     <= up_press;
            rpt_cnt    <= '0;
            state      <= HOLD;
`else
            state      <= WAIT_RELEASE;
`endif
          end
        end
        WAIT_RELEASE: begin
          if (!up_level && !dn_level) state <= IDLE;
        end
`ifdef DUTY_CTRL_AUTOREPEAT_EN
        HOLD, REPEAT: begin
          if (hold_broken) begin
            state <= WAIT_RELEASE;
          end else if (rpt_cnt == ((state == HOLD) ? DELAY_LAST : PERIOD_LAST)) begin
            duty_cycle <= step_val;
            duty_valid <= (step_val != duty_cycle);
            at_max     <= (step_val == MAX7);
            at_min     <= (step_val == '0);
            rpt_cnt    <= '0;
            state      <= REPEAT;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_duty_cycle_ctrl.sv
`default_nettype none

module tb_duty_cycle_ctrl;

  localparam int DEB  = 20;
  localparam int STEP = 10;
  localparam int MAXD = 100;
  localparam int LAT  = DEB + 3;  // drive at negedge K -> pulse seen at negedge K+23

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_dn5;
  logic [6:0] duty_cycle, duty5;
  logic       duty_valid, at_max, at_min;
  logic       valid5, max5, min5, up5;

  duty_cycle_ctrl dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .duty_cycle(duty_cycle), .duty_valid(duty_valid), .at_max(at_max), .at_min(at_min)
  );

  duty_cycle_ctrl #(.INIT_DUTY(5)) dut5 (
    .clk(clk), .rst(rst), .btn_up(up5), .btn_down(btn_dn5),
    .duty_cycle(duty5), .duty_valid(valid5), .at_max(max5), .at_min(min5)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int duty;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_pass   = 0;
  int   n_checks = 0;
  int   n_valid5 = 0;
  int   model;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int step_model(input int v, input bit up);
    if (up) return (v + STEP > MAXD) ? MAXD : v + STEP;
    return (v < STEP) ? 0 : v - STEP;
  endfunction

  // Scoreboard: every duty_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && duty_valid) begin
      if (sbq.size() == 0) begin
        check_eq("unexpected_valid", duty_cycle, -1);
      end else begin
        mon_e = sbq.pop_front();
        check_eq("duty", duty_cycle, mon_e.duty);
        check_eq("valid_cycle", cyc, mon_e.cyc);
        check_eq("at_max", at_max, (mon_e.duty == MAXD) ? 1 : 0);
        check_eq("at_min", at_min, (mon_e.duty == 0) ? 1 : 0);
      end
    end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      mon_e = sbq.pop_front();
      check_eq("missed_valid", 0, mon_e.duty);
    end
    if (rst && valid5) n_valid5++;
  end

  task automatic press(input bit up, input int hi, input int lo);
    int nv;
    @(negedge clk);
    if (up) btn_up = 1'b1; else btn_down = 1'b1;
    nv = step_model(model, up);
    if (nv != model) sbq.push_back('{nv, cyc + LAT});
    model = nv;
    repeat (hi) @(negedge clk);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_dn5 = 1'b0; up5 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_duty", duty_cycle, 50);
    check_eq("rst_at_max", at_max, 0);
    check_eq("rst_at_min", at_min, 0);
    check_eq("rst_valid", duty_valid, 0);
    check_eq("rst_duty5", duty5, 5);
    model = 50;

    // Single clean press, held well past the debounce window.
    press(1'b1, 40, 30);
    check_eq("single_press", duty_cycle, 60);

    // Bouncy contact never stable long enough.
    repeat (4) begin
      @(negedge clk); btn_up = 1'b1;
      repeat (5) @(negedge clk); btn_up = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    check_eq("bounce_hold", duty_cycle, model);

    // Climb into saturation; the last press produces no pulse.
    repeat (5) press(1'b1, 30, 30);
    check_eq("sat_duty", duty_cycle, MAXD);
    check_eq("sat_at_max", at_max, 1);

    // Both buttons together: no step. Then a lone down press.
    @(negedge clk); btn_up = 1'b1; btn_down = 1'b1;
    repeat (40) @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("both_pressed", duty_cycle, model);
    press(1'b0, 30, 30);
    check_eq("down_after_both", duty_cycle, 90);

    // Down from below STEP clamps to zero on the second instance.
    @(negedge clk); btn_dn5 = 1'b1;
    repeat (30) @(negedge clk); btn_dn5 = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("dn5_duty", duty5, 0);
    check_eq("dn5_at_min", min5, 1);
    check_eq("dn5_pulses", n_valid5, 1);

    // Reset while a button is held, then a fresh press after release.
    @(negedge clk); btn_up = 1'b1;
    sbq.push_back('{step_model(model, 1'b1), cyc + LAT});
    repeat (30) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("midhold_rst_duty", duty_cycle, 50);
    check_eq("midhold_rst_valid", duty_valid, 0);
    check_eq("midhold_rst_sb", sbq.size(), 0);
    model = 50;
    @(negedge clk); rst = 1'b1;
    sbq.push_back('{60, cyc + LAT});
    model = 60;
    repeat (40) @(negedge clk);
    btn_up = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("post_rst_press", duty_cycle, 60);

`ifdef DUTY_CTRL_AUTOREPEAT_EN
    begin : auto_repeat
      int c0, t, k, v, nv;
      @(negedge clk); btn_down = 1'b1;
      c0 = cyc; t = cyc + LAT; k = 0; v = model;
      while (t < c0 + 300) begin
        nv = step_model(v, 1'b0);
        if (nv != v) sbq.push_back('{nv, t});
        v = nv;
        t += (k == 0) ? 100 : 20;
        k++;
      end
      model = v;
      repeat (300) @(negedge clk);
      btn_down = 1'b0;
      repeat (40) @(negedge clk);
      check_eq("repeat_final", duty_cycle, 0);
    end
`endif

    check_eq("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
